// File: rtl/pipe_addsub.sv
// Pipelined segmented ripple-carry add/subtract unit with a global-stall valid/ready pipeline.
// Each stage resolves one SEG-bit slice and hands its carry to the next stage.
module pipe_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / SEG;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Inputs of the final stage: resolved lower bits, top operand slice, carry, valid.
  logic [WIDTH-1:0] f_res;
  logic [SEG-1:0]   f_a;
  logic [SEG-1:0]   f_b;
  logic             f_c;
  logic             f_v;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub | cin;

  if (STAGES == 1) begin : g_single
    assign f_res = '0;
    assign f_a   = SEG'(a);
    assign f_b   = SEG'(b_eff);
    assign f_c   = c0;
    assign f_v   = in_valid;
  end else begin : g_multi
    localparam int unsigned RW = WIDTH - SEG;

    // Intermediate stages 0..STAGES-2; operands are kept shifted so the next slice sits at bit 0.
    logic             v_q   [STAGES-1];
    logic             c_q   [STAGES-1];
    logic [WIDTH-1:0] res_q [STAGES-1];
    logic [RW-1:0]    a_q   [STAGES-1];
    logic [RW-1:0]    b_q   [STAGES-1];

    logic             v_n   [STAGES-1];
    logic             c_n   [STAGES-1];
    logic [WIDTH-1:0] res_n [STAGES-1];
    logic [RW-1:0]    a_n   [STAGES-1];
    logic [RW-1:0]    b_n   [STAGES-1];
    logic [SEG:0]     t0;
    logic [SEG:0]     tk;

    always_comb begin
      tk = '0;
      for (int k = 0; k < STAGES - 1; k++) begin
        v_n[k]   = 1'b0;
        c_n[k]   = 1'b0;
        res_n[k] = '0;
        a_n[k]   = '0;
        b_n[k]   = '0;
      end

      t0          = {1'b0, a[SEG-1:0]} + {1'b0, b_eff[SEG-1:0]} + (SEG+1)'(c0);
      v_n[0]      = in_valid;
      c_n[0]      = t0[SEG];
      res_n[0]    = '0;
      res_n[0][SEG-1:0] = t0[SEG-1:0];
      a_n[0]      = a[WIDTH-1:SEG];
      b_n[0]      = b_eff[WIDTH-1:SEG];

      for (int k = 1; k < STAGES - 1; k++) begin
        tk       = {1'b0, a_q[k-1][SEG-1:0]} + {1'b0, b_q[k-1][SEG-1:0]} + (SEG+1)'(c_q[k-1]);
        v_n[k]   = v_q[k-1];
        c_n[k]   = tk[SEG];
        res_n[k] = res_q[k-1];
        res_n[k][k*SEG +: SEG] = tk[SEG-1:0];
        a_n[k]   = a_q[k-1] >> SEG;
        b_n[k]   = b_q[k-1] >> SEG;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < STAGES - 1; k++) begin
          v_q[k]   <= 1'b0;
          c_q[k]   <= 1'b0;
          res_q[k] <= '0;
          a_q[k]   <= '0;
          b_q[k]   <= '0;
        end
      end else if (advance) begin
        for (int k = 0; k < STAGES - 1; k++) begin
          v_q[k]   <= v_n[k];
          c_q[k]   <= c_n[k];
          res_q[k] <= res_n[k];
          a_q[k]   <= a_n[k];
          b_q[k]   <= b_n[k];
        end
      end
    end

    assign f_res = res_q[STAGES-2];
    assign f_a   = a_q[STAGES-2][SEG-1:0];
    assign f_b   = b_q[STAGES-2][SEG-1:0];
    assign f_c   = c_q[STAGES-2];
    assign f_v   = v_q[STAGES-2];
  end

  logic [SEG:0]     ft;
  logic [WIDTH-1:0] sum_n;
  logic             cout_n;
  logic             ovf_n;

  // Final slice; overflow uses the carried-forward operand MSBs.
  always_comb begin
    ft     = {1'b0, f_a} + {1'b0, f_b} + (SEG+1)'(f_c);
    sum_n  = f_res;
    sum_n[WIDTH-1 -: SEG] = ft[SEG-1:0];
    cout_n = ft[SEG];
    ovf_n  = (f_a[SEG-1] == f_b[SEG-1]) && (ft[SEG-1] != f_a[SEG-1]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance) begin
      out_valid <= f_v;
      sum       <= sum_n;
      cout      <= cout_n;
      ovf       <= ovf_n;
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed vector tables, backpressure and reset sequences,
// and a randomized soak scored against an arithmetic reference model.
module tb_pipe_addsub;

  localparam int unsigned W   = 32;
  localparam int unsigned SG  = 8;
  localparam int unsigned STG = W / SG;
  localparam int unsigned DW  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0]  a, b, sum;
  logic          d_in_valid, d_in_ready, d_cin, d_sub, d_out_valid, d_out_ready, d_cout, d_ovf;
  logic [DW-1:0] d_a, d_b, d_sum;

  pipe_addsub #(.WIDTH(W), .SEG(SG)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf));

  pipe_addsub #(.WIDTH(DW), .SEG(DW)) u_deg (
    .clk(clk), .reset(reset), .in_valid(d_in_valid), .in_ready(d_in_ready), .a(d_a), .b(d_b),
    .cin(d_cin), .sub(d_sub), .out_valid(d_out_valid), .out_ready(d_out_ready), .sum(d_sum),
    .cout(d_cout), .ovf(d_ovf));

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    string       name;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   retired = 0;
  bit   soak_done = 0;
  res_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Plain integer arithmetic on a w-bit word, signed view by sign extension.
  function automatic res_t model(input int unsigned w, input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic s);
    res_t   r;
    longint mask, half, ua, ub, sa, sb, full, sres;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'({32'd0, x}) & mask;
    ub   = longint'({32'd0, y}) & mask;
    sa   = (ua >= half) ? ua - (mask + 1) : ua;
    sb   = (ub >= half) ? ub - (mask + 1) : ub;
    if (s) begin
      full   = ua - ub;
      r.cout = (ua >= ub);
      sres   = sa - sb;
    end else begin
      full   = ua + ub + longint'(ci);
      r.cout = ((full >> w) & 1) != 0;
      sres   = sa + sb + longint'(ci);
    end
    r.sum = 32'(full & mask);
    r.ovf = (sres >= half) || (sres < -half);
    return r;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: decided at the falling edge for the following rising edge.
  always @(negedge reset) exp_q.delete();

  initial begin : monitor
    res_t        e;
    bit          hold_prev;
    logic [33:0] prev;
    hold_prev = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        hold_prev = 0;
      end else begin
        if (hold_prev && out_valid) chk("hold_stable", {sum, cout, ovf}, prev);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got sum 0x%0h expected no result", sum);
          end else begin
            e = exp_q.pop_front();
            chk("result_sum", sum, e.sum);
            chk("result_cout", cout, e.cout);
            chk("result_ovf", ovf, e.ovf);
            retired++;
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(W, a, b, cin, sub));
        hold_prev = out_valid && !out_ready;
        prev = {sum, cout, ovf};
      end
    end
  end

  task automatic send_main(input logic [31:0] x, input logic [31:0] y, input logic ci,
                           input logic s);
    bit ok;
    ok = 0;
    in_valid = 1'b1; a = x; b = y; cin = ci; sub = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_vec_main(input vec_t v);
    int lat;
    out_ready = 1'b1;
    send_main(v.a, v.b, v.cin, v.sub);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk({v.name, "_latency"}, lat, STG - 1);
    chk({v.name, "_sum"}, sum, v.sum);
    chk({v.name, "_cout"}, cout, v.cout);
    chk({v.name, "_ovf"}, ovf, v.ovf);
    @(posedge clk); #1;
  endtask

  task automatic run_vec_deg(input string name, input logic [15:0] x, input logic [15:0] y,
                             input logic ci, input logic s, input res_t e);
    int lat;
    bit ok;
    ok = 0;
    d_in_valid = 1'b1; d_a = x; d_b = y; d_cin = ci; d_sub = s;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (d_in_ready) begin ok = 1; break; end
    end
    if (!ok) chk({name, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (d_out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, 0);
    chk({name, "_sum"}, d_sum, e.sum[15:0]);
    chk({name, "_cout"}, d_cout, e.cout);
    chk({name, "_ovf"}, d_ovf, e.ovf);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name, input int base, input int expect_n);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_count"}, retired - base, expect_n);
  endtask

  initial begin : watchdog
    #500us;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t mv[7];
    vec_t dv[3];
    vec_t v;
    res_t e;
    int   r0;
    logic [31:0] s0;

    mv[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "wrap"};
    mv[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "ovf_add"};
    mv[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "ovf_sub"};
    mv[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "borrow"};
    mv[4] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "sub_equal"};
    mv[5] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "seg_carry"};
    mv[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, "neg_ovf"};
    dv[0] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "deg_wrap"};
    dv[1] = '{32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_7FFF, 1'b1, 1'b1, "deg_ovf_sub"};
    dv[2] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_FFFE, 1'b0, 1'b0, "deg_borrow"};

    reset = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    d_in_valid = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0; d_out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_deg_out_valid", d_out_valid, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec_main(mv[i]);

    for (int i = 0; i < 3; i++) begin
      e = '{sum: dv[i].sum, cout: dv[i].cout, ovf: dv[i].ovf};
      run_vec_deg(dv[i].name, dv[i].a[15:0], dv[i].b[15:0], dv[i].cin, dv[i].sub, e);
    end
    for (int i = 0; i < 30; i++) begin
      v.a = {16'd0, 16'($urandom)};
      v.b = {16'd0, 16'($urandom)};
      v.cin = 1'($urandom);
      v.sub = 1'($urandom);
      run_vec_deg("deg_rand", v.a[15:0], v.b[15:0], v.cin, v.sub, model(DW, v.a, v.b, v.cin, v.sub));
    end

    // Backpressure: 8 back-to-back beats, 6-cycle stall from the first result.
    r0 = retired;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_main(rnd32(), rnd32(), 1'($urandom), 1'($urandom));
      end
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        chk("bp_out_valid_seen", out_valid, 1);
        chk("bp_in_ready_drop", in_ready, 0);
        s0 = sum;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("bp_sum_stable", sum, s0);
          chk("bp_in_ready_low", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain("bp", r0, 8);

    // Reset while the first of three beats sits in stage 2.
    out_ready = 1'b1;
    r0 = retired;
    for (int i = 0; i < 3; i++) send_main(rnd32() | 32'h0101_0101, rnd32(), 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_sum", sum, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", in_ready, 1);
    repeat (8) @(posedge clk);
    #1;
    chk("rst_mid_nothing_out", retired - r0, 0);
    v.a = 32'h1111_1111; v.b = 32'h2222_2222; v.cin = 1'b1; v.sub = 1'b0;
    e = model(W, v.a, v.b, v.cin, v.sub);
    v.sum = e.sum; v.cout = e.cout; v.ovf = e.ovf; v.name = "rst_after";
    run_vec_main(v);
    chk("rst_after_count", retired - r0, 1);

    // Reset while a result is presented and stalled: must drop without a clock edge.
    out_ready = 1'b0;
    send_main(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("rst_async_pre_sum", sum, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_out_valid", out_valid, 0);
    chk("rst_async_sum", sum, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Randomized soak with random idle cycles and random out_ready.
    r0 = retired;
    soak_done = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
          send_main(rnd32(), rnd32(), 1'($urandom), 1'($urandom));
        end
        soak_done = 1;
      end
      begin
        while (!soak_done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    drain("soak", r0, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
